f2c_dma_sequencer: RTL and testbench

Sequences the FPGA->CPU DMA path. Streams source data as fixed-size MWr TLPs into the host F2C chunk ring. After each completed chunk it issues a one-QW metrics write of the new write pointer to the F2C_WRPTR slot (metrics base + 0). It honours the host read pointer so the ring never overruns, and it sits between the F2C data FIFO and the TLP transmitter.

---
 rtl/f2c_dma_sequencer.sv | 177 +++++++++++++++++
 tb/tb_f2c_dma_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f2c_dma_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : f2c_dma_sequencer
// Purpose  : Streams source QWs as fixed-size MWr TLPs into the host F2C
//            chunk ring. After each chunk it writes the new write pointer to
//            the metrics buffer. Optional stall counter: F2C_STALL_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module f2c_dma_sequencer #(
    parameter int NUM_CHUNKS = 4,
    parameter int CHUNK_SIZE = 4096,
    parameter int TLP_SIZE   = 128,
    parameter int ADDR_W     = 29
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          dmaEnable_in,
    input  logic                          dmaReset_in,
    input  logic [ADDR_W-1:0]             f2cBase_in,
    input  logic [ADDR_W-1:0]             mtrBase_in,
    input  logic [$clog2(NUM_CHUNKS)-1:0] rdPtr_in,
    input  logic [63:0]                   srcData_in,
    input  logic                          srcValid_in,
    output logic                          srcReady_out,
    output logic                          reqValid_out,
    input  logic                          reqReady_in,
    output logic [ADDR_W-1:0]             reqAddr_out,
    output logic [7:0]                    reqLenQw_out,
    output logic [63:0]                   txData_out,
    output logic                          txValid_out,
    input  logic                          txReady_in,
    output logic                          txLast_out,
    output logic [$clog2(NUM_CHUNKS)-1:0] wrPtr_out,
`ifdef F2C_STALL_COUNT_EN
    output logic [31:0]                   stallCount_out,
`endif
    output logic                          busy_out
);

    localparam int PTR_W    = $clog2(NUM_CHUNKS);
    localparam int TLPS     = CHUNK_SIZE / TLP_SIZE;
    localparam int QWS      = TLP_SIZE / 8;
    localparam int CHUNK_QW = CHUNK_SIZE / 8;
    localparam int TLP_W    = (TLPS > 1) ? $clog2(TLPS) : 1;
    localparam int QW_W     = (QWS > 1) ? $clog2(QWS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DHDR  = 3'd1,
        S_DDATA = 3'd2,
        S_MHDR  = 3'd3,
        S_MDATA = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [PTR_W-1:0] r_wrPtr;
    logic [TLP_W-1:0] r_tlpIdx;
    logic [QW_W-1:0]  r_qwIdx;
    logic             r_rstPend;

    logic [PTR_W-1:0]  w_wrPtrInc;
    logic              w_full;
    logic              w_rstReq;
    logic              w_start;
    logic              w_beat;
    logic              w_lastQw;
    logic              w_lastTlp;
    logic              w_applyRst;
    logic [ADDR_W-1:0] w_dataAddr;

    assign w_wrPtrInc = r_wrPtr + PTR_W'(1);
    assign w_full     = (w_wrPtrInc == rdPtr_in);
    // A fresh dmaReset pulse counts as pending so it beats a same-cycle start.
    assign w_rstReq   = r_rstPend | dmaReset_in;
    assign w_applyRst = (r_state == S_IDLE) && w_rstReq;
    assign w_start    = dmaEnable_in & ~w_full & srcValid_in;
    assign w_beat     = srcValid_in & txReady_in;
    assign w_lastQw   = (r_qwIdx == QW_W'(QWS - 1));
    assign w_lastTlp  = (r_tlpIdx == TLP_W'(TLPS - 1));
    assign w_dataAddr = f2cBase_in
                      + ADDR_W'(r_wrPtr) * ADDR_W'(CHUNK_QW)
                      + ADDR_W'(r_tlpIdx) * ADDR_W'(QWS);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_rstReq && w_start) w_next = S_DHDR;
            S_DHDR:  if (reqReady_in) w_next = S_DDATA;
            S_DDATA: if (w_beat && w_lastQw) w_next = w_lastTlp ? S_MHDR : S_DHDR;
            S_MHDR:  if (reqReady_in) w_next = S_MDATA;
            S_MDATA: if (txReady_in) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        reqValid_out = 1'b0;
        reqAddr_out  = '0;
        reqLenQw_out = '0;
        txData_out   = '0;
        txValid_out  = 1'b0;
        txLast_out   = 1'b0;
        srcReady_out = 1'b0;
        case (r_state)
            S_DHDR: begin
                reqValid_out = 1'b1;
                reqAddr_out  = w_dataAddr;
                reqLenQw_out = 8'(QWS);
            end
            S_DDATA: begin
                txValid_out  = srcValid_in;
                srcReady_out = txReady_in;
                txData_out   = srcData_in;
                txLast_out   = w_lastQw;
            end
            S_MHDR: begin
                reqValid_out = 1'b1;
                reqAddr_out  = mtrBase_in;
                reqLenQw_out = 8'd1;
            end
            S_MDATA: begin
                txValid_out = 1'b1;
                txLast_out  = 1'b1;
                txData_out  = 64'(w_wrPtrInc);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= S_IDLE;
            r_wrPtr   <= '0;
            r_tlpIdx  <= '0;
            r_qwIdx   <= '0;
            r_rstPend <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_applyRst) begin
                r_wrPtr   <= '0;
                r_rstPend <= 1'b0;
            end else begin
                if (dmaReset_in) r_rstPend <= 1'b1;
                if (r_state == S_MDATA && txReady_in) r_wrPtr <= w_wrPtrInc;
            end
            if (r_state == S_DHDR && reqReady_in) begin
                r_qwIdx <= '0;
            end else if (r_state == S_DDATA && w_beat) begin
                r_qwIdx <= r_qwIdx + QW_W'(1);
            end
            if (r_state == S_DDATA && w_beat && w_lastQw) begin
                r_tlpIdx <= w_lastTlp ? '0 : r_tlpIdx + TLP_W'(1);
            end
        end
    end

`ifdef F2C_STALL_COUNT_EN
    logic [31:0] r_stallCnt;

    always_ff @(posedge clk_in) begin
        if (rst_in || w_applyRst) begin
            r_stallCnt <= '0;
        end else if (r_state == S_IDLE && dmaEnable_in && srcValid_in && w_full
                     && r_stallCnt != 32'hFFFF_FFFF) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stallCount_out = r_stallCnt;
`endif

    assign wrPtr_out = r_wrPtr;
    assign busy_out  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_f2c_dma_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_f2c_dma_sequencer
// Purpose  : Self-checking bench for f2c_dma_sequencer (ring of 4 x 256B
//            chunks, 128B TLPs); covers F2C_STALL_COUNT_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_f2c_dma_sequencer;

    localparam int NUM_CHUNKS = 4;
    localparam int CHUNK_SIZE = 256;
    localparam int TLP_SIZE   = 128;
    localparam int ADDR_W     = 29;
    localparam int QWS        = TLP_SIZE / 8;
    localparam int TLPS       = CHUNK_SIZE / TLP_SIZE;
    localparam int CHUNK_QW   = CHUNK_SIZE / 8;

    logic        clk = 1'b0;
    logic        rst, dmaEnable, dmaReset;
    logic [28:0] f2cBase, mtrBase;
    logic [1:0]  rdPtr;
    logic [63:0] srcData;
    logic        srcValid, srcReady, reqValid, reqReady;
    logic [28:0] reqAddr;
    logic [7:0]  reqLen;
    logic [63:0] txData;
    logic        txValid, txReady, txLast;
    logic [1:0]  wrPtr;
    logic        busy;
`ifdef F2C_STALL_COUNT_EN
    logic [31:0] stallCount;
`endif

    always #5 clk = ~clk;

    f2c_dma_sequencer #(
        .NUM_CHUNKS(NUM_CHUNKS), .CHUNK_SIZE(CHUNK_SIZE),
        .TLP_SIZE(TLP_SIZE), .ADDR_W(ADDR_W)
    ) u_dut (
        .clk_in(clk), .rst_in(rst), .dmaEnable_in(dmaEnable), .dmaReset_in(dmaReset),
        .f2cBase_in(f2cBase), .mtrBase_in(mtrBase), .rdPtr_in(rdPtr),
        .srcData_in(srcData), .srcValid_in(srcValid), .srcReady_out(srcReady),
        .reqValid_out(reqValid), .reqReady_in(reqReady), .reqAddr_out(reqAddr),
        .reqLenQw_out(reqLen), .txData_out(txData), .txValid_out(txValid),
        .txReady_in(txReady), .txLast_out(txLast), .wrPtr_out(wrPtr),
`ifdef F2C_STALL_COUNT_EN
        .stallCount_out(stallCount),
`endif
        .busy_out(busy)
    );

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  rnd    = 1'b0;
    int  src_idx = 0;
    int  exp_src = 0;
    int  mwr     = 0;
    logic [63:0] q_ha[$], q_hl[$], q_bd[$], q_bl[$];

    typedef struct {
        logic [28:0] base;
        logic [28:0] mtr;
        logic [1:0]  rd;
        bit          en;
        bit          start;
        logic [28:0] a0;
        logic [63:0] md;
        logic [1:0]  wr_after;
    } vec_t;
    vec_t vt[9];

    function automatic logic [63:0] pat(input int i);
        logic [31:0] v;
        v = 32'(i);
        return {v ^ 32'hA5A5_0000, ~v};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Source model: the presented QW advances only on an accepted handshake.
    always @(posedge clk) begin
        if (!rst && srcValid && srcReady) src_idx <= src_idx + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (reqValid && reqReady) begin
                q_ha.push_back(64'(reqAddr));
                q_hl.push_back(64'(reqLen));
            end
            if (txValid && txReady) begin
                q_bd.push_back(txData);
                q_bl.push_back(64'(txLast));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rnd) begin
            reqReady = 1'($urandom_range(0, 1));
            txReady  = 1'($urandom_range(0, 1));
            srcValid = ($urandom_range(0, 3) != 0);
        end
        srcData = pat(src_idx);
    endtask

    task automatic flush();
        q_ha.delete(); q_hl.delete(); q_bd.delete(); q_bl.delete();
    endtask

    task automatic wait_chunk(input int maxc, output bit started);
        bit done;
        done    = 1'b0;
        started = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            cycle();
            if (busy) started = 1'b1;
            else if (started) done = 1'b1;
        end
        dmaEnable = 1'b0;
        chk("chunk_finish_in_time", 64'(done), 64'(started));
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 200 && q_bd.size() < n; i++) cycle();
        chk("reach_beats", (q_bd.size() >= n) ? 64'd1 : 64'd0, 64'd1);
    endtask

    // Expected chunk: TLPS headers stepping by QWS, sequential source QWs
    // with last on every QWS-th beat, then one metrics header and QW.
    task automatic check_chunk(input logic [28:0] a0, input logic [28:0] ma,
                               input logic [63:0] md);
        logic [28:0] a;
        chk("hdr_count", 64'(q_ha.size()), 64'(TLPS + 1));
        chk("beat_count", 64'(q_bd.size()), 64'(TLPS * QWS + 1));
        if (q_ha.size() == TLPS + 1 && q_bd.size() == TLPS * QWS + 1) begin
            for (int t = 0; t < TLPS; t++) begin
                a = a0 + 29'(t * QWS);
                chk("hdr_addr", q_ha[t], 64'(a));
                chk("hdr_len", q_hl[t], 64'(QWS));
            end
            chk("mtr_addr", q_ha[TLPS], 64'(ma));
            chk("mtr_len", q_hl[TLPS], 64'd1);
            for (int b = 0; b < TLPS * QWS; b++) begin
                chk("payload", q_bd[b], pat(exp_src));
                exp_src++;
                chk("payload_last", q_bl[b], (b % QWS == QWS - 1) ? 64'd1 : 64'd0);
            end
            chk("mtr_data", q_bd[TLPS * QWS], md);
            chk("mtr_last", q_bl[TLPS * QWS], 64'd1);
        end
        exp_src = src_idx;
        flush();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        logic [28:0] a0;

        vt[0] = '{29'h100,  29'h800,  2'd0, 1'b1, 1'b1, 29'h100,  64'd1, 2'd1};
        vt[1] = '{29'h100,  29'h800,  2'd0, 1'b1, 1'b1, 29'h120,  64'd2, 2'd2};
        vt[2] = '{29'h100,  29'h800,  2'd0, 1'b1, 1'b1, 29'h140,  64'd3, 2'd3};
        vt[3] = '{29'h100,  29'h800,  2'd0, 1'b1, 1'b0, 29'h0,    64'd0, 2'd3};
        vt[4] = '{29'h100,  29'h800,  2'd1, 1'b0, 1'b0, 29'h0,    64'd0, 2'd3};
        vt[5] = '{29'h100,  29'h800,  2'd1, 1'b1, 1'b1, 29'h160,  64'd0, 2'd0};
        vt[6] = '{29'h100,  29'h800,  2'd2, 1'b1, 1'b1, 29'h100,  64'd1, 2'd1};
        vt[7] = '{29'h2000, 29'h3000, 2'd3, 1'b1, 1'b1, 29'h2020, 64'd2, 2'd2};
        vt[8] = '{29'h2000, 29'h3000, 2'd3, 1'b1, 1'b0, 29'h0,    64'd0, 2'd2};

        rst = 1'b1; dmaEnable = 1'b0; dmaReset = 1'b0;
        f2cBase = 29'h100; mtrBase = 29'h800; rdPtr = 2'd0;
        srcValid = 1'b1; reqReady = 1'b1; txReady = 1'b1; srcData = pat(0);
        repeat (3) cycle();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_reqValid", 64'(reqValid), 64'd0);
        chk("rst_txValid", 64'(txValid), 64'd0);
        chk("rst_srcReady", 64'(srcReady), 64'd0);
        chk("rst_txLast", 64'(txLast), 64'd0);
        chk("rst_wrPtr", 64'(wrPtr), 64'd0);
        chk("rst_reqAddr", 64'(reqAddr), 64'd0);
        chk("rst_txData", txData, 64'd0);
        rst = 1'b0;
        cycle();
        exp_src = src_idx;

`ifdef F2C_STALL_COUNT_EN
        rdPtr = 2'd1;
        dmaEnable = 1'b1;
        repeat (50) cycle();
        dmaEnable = 1'b0;
        chk("stall_count_50", 64'(stallCount), 64'd50);
        chk("stall_busy", 64'(busy), 64'd0);
        cycle();
        chk("stall_hold", 64'(stallCount), 64'd50);
        dmaReset = 1'b1;
        cycle();
        dmaReset = 1'b0;
        chk("stall_cleared", 64'(stallCount), 64'd0);
        rdPtr = 2'd0;
        flush();
`endif

        for (int v = 0; v < 9; v++) begin
            f2cBase   = vt[v].base;
            mtrBase   = vt[v].mtr;
            rdPtr     = vt[v].rd;
            dmaEnable = vt[v].en;
            cycle();
            chk("start_latency", 64'(reqValid), 64'(vt[v].start));
            wait_chunk(200, st);
            chk("started", 64'(st), 64'(vt[v].start));
            if (vt[v].start) check_chunk(vt[v].a0, vt[v].mtr, vt[v].md);
            else chk("no_traffic", 64'(q_ha.size() + q_bd.size()), 64'd0);
            chk("wrptr_after", 64'(wrPtr), 64'(vt[v].wr_after));
            chk("idle_after", 64'(busy), 64'd0);
        end
        mwr = 2;

        f2cBase = 29'h100; mtrBase = 29'h800; rdPtr = 2'd0; dmaEnable = 1'b1;
        wait_beats(10);
        dmaReset = 1'b1;
        cycle();
        dmaReset = 1'b0;
        wait_chunk(200, st);
        check_chunk(29'h140, 29'h800, 64'd3);
        chk("dmarst_wrptr_pre", 64'(wrPtr), 64'd3);
        cycle();
        chk("dmarst_wrptr_clr", 64'(wrPtr), 64'd0);
        mwr = 0;

        rdPtr = 2'd0; dmaEnable = 1'b1;
        wait_beats(5);
        dmaEnable = 1'b0;
        wait_chunk(200, st);
        check_chunk(29'h100, 29'h800, 64'd1);
        chk("endrop_wrptr", 64'(wrPtr), 64'd1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("endrop_idle", 64'(busy | reqValid), 64'd0);
        end
        mwr = 1;

        rnd = 1'b1;
        for (int k = 0; k < 6; k++) begin
            f2cBase = 29'($urandom);
            mtrBase = 29'($urandom);
            rdPtr   = 2'(mwr);
            dmaEnable = 1'b1;
            wait_chunk(3000, st);
            chk("rnd_started", 64'(st), 64'd1);
            a0 = f2cBase + 29'(mwr * CHUNK_QW);
            check_chunk(a0, mtrBase, 64'((mwr + 1) % NUM_CHUNKS));
            mwr = (mwr + 1) % NUM_CHUNKS;
            chk("rnd_wrptr", 64'(wrPtr), 64'(mwr));
        end
        rnd = 1'b0; reqReady = 1'b1; txReady = 1'b1; srcValid = 1'b1;

        f2cBase = 29'h100; mtrBase = 29'h800; rdPtr = 2'(mwr); dmaEnable = 1'b1;
        wait_beats(3);
        rst = 1'b1; dmaEnable = 1'b0;
        cycle();
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_reqValid", 64'(reqValid), 64'd0);
        chk("midrst_txValid", 64'(txValid), 64'd0);
        chk("midrst_srcReady", 64'(srcReady), 64'd0);
        chk("midrst_wrptr", 64'(wrPtr), 64'd0);
        rst = 1'b0;
        flush();
        exp_src = src_idx;
        mwr = 0;

        rdPtr = 2'd0; dmaEnable = 1'b1;
        wait_chunk(200, st);
        chk("recover_started", 64'(st), 64'd1);
        check_chunk(29'h100, 29'h800, 64'd1);
        chk("recover_wrptr", 64'(wrPtr), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
